// File: rtl/raytracing_ram_pkg.sv
// -----------------------------------------------------------------------------
// raytracing_ram_pkg
// Shared definitions for the ray-tracing frame RAM and its two-port arbiter.
// The memory-side constants are the single source of truth for both the RAM
// instance and raytracing_ram_arbiter. port_id_t names the two master ports.
// -----------------------------------------------------------------------------
package raytracing_ram_pkg;

   localparam int RAM_ADDR_W = 16;     // word-address width
   localparam int RAM_DATA_W = 32;     // data width
   localparam int RAM_DEPTH  = 38400;  // number of valid words

   typedef enum logic {
      PORT_M0 = 1'b0,
      PORT_M1 = 1'b1
   } port_id_t;

endpackage

// File: rtl/raytracing_rr_arb2.sv
// -----------------------------------------------------------------------------
// raytracing_rr_arb2
// Two-requester round-robin arbiter. At most one grant per cycle.
// On contention the port that did not win last time is granted; a lone
// requester always wins. The last-grant register only moves on a grant.
//
// Ports:
//   clk           clock
//   reset         asynchronous active-high reset (last grant -> port 1,
//                 so port 0 wins the first contention)
//   i_en          grant enable; no grant is produced while low
//   i_req[1:0]    request per port
//   o_grant[1:0]  one-hot (or zero) grant, combinational
// -----------------------------------------------------------------------------
module raytracing_rr_arb2
   import raytracing_ram_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       i_en,
   input  logic [1:0] i_req,
   output logic [1:0] o_grant
);

   port_id_t   r_last_grant;
   logic [1:0] w_grant;

   always_comb begin
      w_grant = 2'b00;
      if (i_en) begin
         if (i_req == 2'b11) begin
            w_grant = (r_last_grant == PORT_M1) ? 2'b01 : 2'b10;
         end else begin
            w_grant = i_req;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_last_grant <= PORT_M1;
      end else if (w_grant[0]) begin
         r_last_grant <= PORT_M0;
      end else if (w_grant[1]) begin
         r_last_grant <= PORT_M1;
      end
   end

   assign o_grant = w_grant;

endmodule

// File: rtl/raytracing_ram_arbiter.sv
// -----------------------------------------------------------------------------
// raytracing_ram_arbiter
// Shares one single-port RAM (1-cycle read latency) between two Avalon-MM
// style masters m0/m1 using round-robin arbitration.
//
// Handshake: a port requests with read or write high (both high = write).
// The request is accepted in the cycle its waitrequest is 0; a waiting port
// must hold its request stable. An accepted read returns exactly one
// readdatavalid pulse on the issuing port in the following cycle.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   reset_req           quiesce: no grants, clock-enable to RAM low
//   mN_*                master port N (address/byteenable/read/write/
//                       writedata in; waitrequest/readdata/readdatavalid out)
//   ram_*               RAM side; ram_readdata is RAM q
//   oor_err             sticky: an access at address >= DEPTH was seen
//
// Out-of-range accesses are accepted but never reach the RAM: writes are
// dropped, reads return zero with the normal one-cycle timing.
// -----------------------------------------------------------------------------
module raytracing_ram_arbiter
   import raytracing_ram_pkg::*;
#(
   parameter int ADDR_W = RAM_ADDR_W,
   parameter int DATA_W = RAM_DATA_W,
   parameter int DEPTH  = RAM_DEPTH,
   parameter int BE_W   = DATA_W / 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              reset_req,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] ram_address,
   output logic [BE_W-1:0]   ram_byteenable,
   output logic              ram_chipselect,
   output logic              ram_write,
   output logic [DATA_W-1:0] ram_writedata,
   output logic              ram_clken,
   input  logic [DATA_W-1:0] ram_readdata,
   output logic              oor_err
);

   // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

   logic              w_en;
   logic [1:0]        w_req;
   logic [1:0]        w_grant;
   logic              w_granted;
   port_id_t          w_sel;
   logic [ADDR_W-1:0] w_addr;
   logic [BE_W-1:0]   w_be;
   logic [DATA_W-1:0] w_wdata;
   logic              w_wr;
   logic              w_oor;
   logic              w_issue;

   logic              r_rd_pending;
   port_id_t          r_rd_port;
   logic              r_rd_oor;
   logic              r_oor_err;

   // Gating with reset keeps every combinational output at its idle value
   // while reset is held, not just from the next clock edge.
   assign w_en  = ~reset & ~reset_req;
   assign w_req = {m1_read | m1_write, m0_read | m0_write};

   raytracing_rr_arb2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .i_en    (w_en),
      .i_req   (w_req),
      .o_grant (w_grant)
   );

   assign w_granted = |w_grant;
   assign w_sel     = w_grant[1] ? PORT_M1 : PORT_M0;
   assign w_addr    = w_grant[1] ? m1_address    : m0_address;
   assign w_be      = w_grant[1] ? m1_byteenable : m0_byteenable;
   assign w_wdata   = w_grant[1] ? m1_writedata  : m0_writedata;
   assign w_wr      = w_grant[1] ? m1_write      : m0_write;
   assign w_oor     = ({1'b0, w_addr} >= DEPTH_V);
   assign w_issue   = w_granted & ~w_oor;

   assign ram_chipselect = w_issue;
   assign ram_write      = w_issue & w_wr;
   assign ram_address    = w_issue ? w_addr  : '0;
   assign ram_byteenable = w_issue ? w_be    : '0;
   assign ram_writedata  = w_issue ? w_wdata : '0;
   assign ram_clken      = w_en;

   assign m0_waitrequest = ~w_grant[0];
   assign m1_waitrequest = ~w_grant[1];

   // Read-return tracking: one outstanding read at most, since RAM latency
   // is one cycle; a new read can be granted in the same cycle a return
   // is delivered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_pending <= 1'b0;
         r_rd_port    <= PORT_M0;
         r_rd_oor     <= 1'b0;
         r_oor_err    <= 1'b0;
      end else begin
         r_rd_pending <= w_granted & ~w_wr;
         r_rd_port    <= w_sel;
         r_rd_oor     <= w_oor;
         if (w_granted & w_oor) begin
            r_oor_err <= 1'b1;
         end
      end
   end

   assign m0_readdatavalid = r_rd_pending & (r_rd_port == PORT_M0);
   assign m1_readdatavalid = r_rd_pending & (r_rd_port == PORT_M1);
   assign m0_readdata      = (m0_readdatavalid & ~r_rd_oor) ? ram_readdata : '0;
   assign m1_readdata      = (m1_readdatavalid & ~r_rd_oor) ? ram_readdata : '0;
   assign oor_err          = r_oor_err;

endmodule

// File: tb/tb_raytracing_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_raytracing_ram_arbiter
// Directed scenarios followed by a randomized phase. Inputs change on the
// falling edge; outputs are checked 1 time unit later against a reference
// model built from the arbitration rules (tie goes to the port that lost
// last time, reads return one cycle later, out-of-range reads return 0).
// -----------------------------------------------------------------------------
module tb_raytracing_ram_arbiter;

   localparam int AW      = 16;
   localparam int DW      = 32;
   localparam int BW      = 4;
   localparam int DEPTH_C = 38400;

   logic          clk = 1'b0;
   logic          reset;
   logic          reset_req;
   logic [AW-1:0] m0_address, m1_address;
   logic [BW-1:0] m0_byteenable, m1_byteenable;
   logic          m0_read, m0_write, m1_read, m1_write;
   logic [DW-1:0] m0_writedata, m1_writedata;
   logic          m0_waitrequest, m1_waitrequest;
   logic [DW-1:0] m0_readdata, m1_readdata;
   logic          m0_readdatavalid, m1_readdatavalid;
   logic [AW-1:0] ram_address;
   logic [BW-1:0] ram_byteenable;
   logic          ram_chipselect, ram_write, ram_clken;
   logic [DW-1:0] ram_writedata;
   logic [DW-1:0] ram_readdata;
   logic          oor_err;

   raytracing_ram_arbiter dut (
      .clk              (clk),
      .reset            (reset),
      .reset_req        (reset_req),
      .m0_address       (m0_address),
      .m0_byteenable    (m0_byteenable),
      .m0_read          (m0_read),
      .m0_write         (m0_write),
      .m0_writedata     (m0_writedata),
      .m0_waitrequest   (m0_waitrequest),
      .m0_readdata      (m0_readdata),
      .m0_readdatavalid (m0_readdatavalid),
      .m1_address       (m1_address),
      .m1_byteenable    (m1_byteenable),
      .m1_read          (m1_read),
      .m1_write         (m1_write),
      .m1_writedata     (m1_writedata),
      .m1_waitrequest   (m1_waitrequest),
      .m1_readdata      (m1_readdata),
      .m1_readdatavalid (m1_readdatavalid),
      .ram_address      (ram_address),
      .ram_byteenable   (ram_byteenable),
      .ram_chipselect   (ram_chipselect),
      .ram_write        (ram_write),
      .ram_writedata    (ram_writedata),
      .ram_clken        (ram_clken),
      .ram_readdata     (ram_readdata),
      .oor_err          (oor_err)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int         n_cmp = 0;
   int         n_err = 0;
   logic [1:0] exp_q[$];      // outstanding reads: {port, out_of_range}
   bit         m_prefer0;     // port 0 wins the next tie
   bit         m_oor;         // expected sticky error flag
   int         g_win;         // winner of the last checked cycle (-1 none)

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic drive_idle();
      m0_read = 0; m0_write = 0; m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
      m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
   endtask

   task automatic drive_m(input int p, input logic rd, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [BW-1:0] be);
      if (p == 0) begin
         m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
      end else begin
         m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
      end
   endtask

   // Called right after inputs were set on a falling edge.
   task automatic check_cycle();
      logic          rq0, rq1, wr, oor, iss;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [BW-1:0] be;
      logic [1:0]    it;
      logic          e_rdv0, e_rdv1;
      logic [DW-1:0] e_rd0, e_rd1;
      int            win;
      #1;
      if (reset) begin
         exp_q.delete();
         m_prefer0 = 1'b1;
         m_oor     = 1'b0;
         g_win     = -1;
         chk("rst_m0_wait", m0_waitrequest, 1);
         chk("rst_m1_wait", m1_waitrequest, 1);
         chk("rst_m0_rdv", m0_readdatavalid, 0);
         chk("rst_m1_rdv", m1_readdatavalid, 0);
         chk("rst_m0_rdata", m0_readdata, 0);
         chk("rst_m1_rdata", m1_readdata, 0);
         chk("rst_ram_cs", ram_chipselect, 0);
         chk("rst_ram_wr", ram_write, 0);
         chk("rst_ram_clken", ram_clken, 0);
         chk("rst_ram_addr", 32'(ram_address), 0);
         chk("rst_ram_be", 32'(ram_byteenable), 0);
         chk("rst_ram_wdata", ram_writedata, 0);
         chk("rst_oor_err", oor_err, 0);
         return;
      end
      // read return owed from the previous cycle
      e_rdv0 = 0; e_rdv1 = 0; e_rd0 = '0; e_rd1 = '0;
      if (exp_q.size() > 0) begin
         it = exp_q.pop_front();
         if (it[1]) begin
            e_rdv1 = 1; e_rd1 = it[0] ? '0 : ram_readdata;
         end else begin
            e_rdv0 = 1; e_rd0 = it[0] ? '0 : ram_readdata;
         end
      end
      // who wins this cycle
      rq0 = m0_read | m0_write;
      rq1 = m1_read | m1_write;
      win = -1;
      if (!reset_req) begin
         if (rq0 && rq1) win = m_prefer0 ? 0 : 1;
         else if (rq0)   win = 0;
         else if (rq1)   win = 1;
      end
      wr = 0; a = '0; d = '0; be = '0;
      if (win == 0) begin
         wr = m0_write; a = m0_address; d = m0_writedata; be = m0_byteenable;
      end else if (win == 1) begin
         wr = m1_write; a = m1_address; d = m1_writedata; be = m1_byteenable;
      end
      oor = (win >= 0) && (int'(a) >= DEPTH_C);
      iss = (win >= 0) && !oor;

      chk("m0_wait", m0_waitrequest, (win != 0));
      chk("m1_wait", m1_waitrequest, (win != 1));
      chk("ram_clken", ram_clken, !reset_req);
      chk("ram_cs", ram_chipselect, iss);
      chk("ram_write", ram_write, iss && wr);
      chk("ram_addr", 32'(ram_address), iss ? 32'(a) : 32'd0);
      chk("ram_be", 32'(ram_byteenable), iss ? 32'(be) : 32'd0);
      chk("ram_wdata", ram_writedata, iss ? d : 32'd0);
      chk("m0_rdv", m0_readdatavalid, e_rdv0);
      chk("m1_rdv", m1_readdatavalid, e_rdv1);
      chk("m0_rdata", m0_readdata, e_rd0);
      chk("m1_rdata", m1_readdata, e_rd1);
      chk("oor_err", oor_err, m_oor);

      g_win = win;
      if (win >= 0) begin
         m_prefer0 = (win == 1);
         if (oor) m_oor = 1'b1;
         if (!wr) exp_q.push_back({(win == 1), oor});
      end
   endtask

   // ---------------- random-phase request holders ----------------
   logic          act[2];
   logic          r_rd[2], r_wr[2];
   logic [AW-1:0] r_a[2];
   logic [DW-1:0] r_d[2];
   logic [BW-1:0] r_be[2];

   function automatic logic [AW-1:0] pick_addr();
      case ($urandom_range(0, 3))
         0:       return AW'(DEPTH_C - 1);
         1:       return AW'(DEPTH_C);
         2:       return AW'($urandom);
         default: return AW'($urandom_range(0, 63));
      endcase
   endfunction

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   // ---------------- stimulus ----------------
   initial begin
      reset = 1; reset_req = 0; ram_readdata = '0;
      drive_idle();
      g_win = -1;
      repeat (2) begin @(negedge clk); check_cycle(); end

      // single m0 read, data returns next cycle
      @(negedge clk); reset = 0;
      drive_m(0, 1, 0, 16'h0010, '0, '0); ram_readdata = $urandom;
      check_cycle();
      chk("s1_m0_wait", m0_waitrequest, 0);
      @(negedge clk); drive_idle(); ram_readdata = 32'hDEADBEEF;
      check_cycle();
      chk("s1_m0_rdv", m0_readdatavalid, 1);
      chk("s1_m0_rdata", m0_readdata, 32'hDEADBEEF);

      // both write every cycle after reset: m0,m1,m0,m1
      @(negedge clk); reset = 1; check_cycle();
      @(negedge clk); reset = 0;
      for (int i = 0; i < 4; i++) begin
         drive_m(0, 0, 1, AW'($urandom_range(0, 1000)), $urandom, 4'hF);
         drive_m(1, 0, 1, AW'($urandom_range(0, 1000)), $urandom, 4'hF);
         check_cycle();
         chk("s2_m0_wait", m0_waitrequest, (i % 2));
         chk("s2_m1_wait", m1_waitrequest, ((i + 1) % 2));
         @(negedge clk);
      end
      drive_idle(); check_cycle();

      // out-of-range write, then last valid word read
      @(negedge clk); drive_m(1, 0, 1, 16'h9600, 32'h12345678, 4'hF);
      check_cycle();
      chk("s3_oor_cs", ram_chipselect, 0);
      chk("s3_m1_wait", m1_waitrequest, 0);
      @(negedge clk); drive_idle(); drive_m(0, 1, 0, 16'h95FF, '0, '0);
      check_cycle();
      chk("s3_oor_err", oor_err, 1);
      chk("s3_rd_cs", ram_chipselect, 1);
      chk("s3_rd_addr", 32'(ram_address), 32'h95FF);
      @(negedge clk); drive_idle(); ram_readdata = 32'hCAFE0001; check_cycle();
      chk("s3_rdata", m0_readdata, 32'hCAFE0001);
      @(negedge clk); check_cycle();
      chk("s3_oor_sticky", oor_err, 1);

      // m1 back-to-back reads
      @(negedge clk); drive_m(1, 1, 0, 16'h0001, '0, '0); check_cycle();
      @(negedge clk); drive_m(1, 1, 0, 16'h0002, '0, '0); ram_readdata = 32'hA1A1A1A1;
      check_cycle();
      chk("s4_rdv1", m1_readdatavalid, 1);
      chk("s4_rdata1", m1_readdata, 32'hA1A1A1A1);
      chk("s4_wait2", m1_waitrequest, 0);
      @(negedge clk); drive_idle(); ram_readdata = 32'hA2A2A2A2;
      check_cycle();
      chk("s4_rdv2", m1_readdatavalid, 1);
      chk("s4_rdata2", m1_readdata, 32'hA2A2A2A2);
      @(negedge clk); check_cycle();

      // quiesce while both request
      drive_m(0, 0, 1, 16'h0100, 32'h11111111, 4'h3);
      drive_m(1, 1, 0, 16'h0200, '0, '0);
      reset_req = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); check_cycle();
         chk("s5_clken", ram_clken, 0);
         chk("s5_waits", {m0_waitrequest, m1_waitrequest}, 2'b11);
      end
      @(negedge clk); reset_req = 0; check_cycle();
      chk("s5_resume", m0_waitrequest & m1_waitrequest, 0);
      @(negedge clk); drive_idle(); check_cycle();

      // reset one cycle after an accepted read
      @(negedge clk); drive_m(0, 1, 0, 16'h0040, '0, '0); check_cycle();
      @(negedge clk); drive_idle(); reset = 1; ram_readdata = 32'h55AA55AA; check_cycle();
      chk("s6_no_rdv", m0_readdatavalid, 0);
      @(negedge clk); reset = 0; check_cycle();
      chk("s6_after_rdv", m0_readdatavalid, 0);

      // randomized traffic; a waiting request is held until granted
      act[0] = 0; act[1] = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         reset     = ($urandom_range(0, 59) == 0);
         reset_req = ($urandom_range(0, 7) == 0);
         ram_readdata = $urandom;
         for (int p = 0; p < 2; p++) begin
            if (!act[p] && $urandom_range(0, 1) == 1) begin
               act[p] = 1;
               case ($urandom_range(0, 2))
                  0:       begin r_rd[p] = 1; r_wr[p] = 0; end
                  1:       begin r_rd[p] = 0; r_wr[p] = 1; end
                  default: begin r_rd[p] = 1; r_wr[p] = 1; end
               endcase
               r_a[p]  = pick_addr();
               r_d[p]  = $urandom;
               r_be[p] = BW'($urandom);
            end
            if (act[p]) drive_m(p, r_rd[p], r_wr[p], r_a[p], r_d[p], r_be[p]);
            else        drive_m(p, 0, 0, '0, '0, '0);
         end
         check_cycle();
         if (g_win >= 0) act[g_win] = 0;
         if (reset) begin act[0] = 0; act[1] = 0; end
      end
      @(negedge clk); reset = 0; reset_req = 0; drive_idle(); check_cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/raytracing_ram_arbiter.md
RAYTRACING_RAM_ARBITER -- requirements
Module: raytracing_ram_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning): ADDR_W 16 word-address width; DATA_W 32 data width; DEPTH 38400 valid words; BE_W DATA_W/8 byte-enable width.
REQ-002 Ports SHALL be (name direction width meaning):
- clk in 1: single clock.
- reset in 1: asynchronous, active-high reset.
- reset_req in 1: quiesce request; no grants while high.
- mN_address in ADDR_W: word address, N = 0,1.
- mN_byteenable in BE_W: byte lanes for writes.
- mN_read in 1: read request.
- mN_write in 1: write request.
- mN_writedata in DATA_W: write data.
- mN_waitrequest out 1: request not accepted this cycle.
- mN_readdata out DATA_W: read data.
- mN_readdatavalid out 1: readdata valid pulse.
- ram_address out ADDR_W: to RAM.
- ram_byteenable out BE_W: to RAM.
- ram_chipselect out 1: to RAM.
- ram_write out 1: to RAM.
- ram_writedata out DATA_W: to RAM.
- ram_clken out 1: to RAM.
- ram_readdata in DATA_W: RAM q, valid one cycle after the read address is presented.
- oor_err out 1: sticky flag, out-of-range access seen.

Function
REQ-003 A request SHALL be mN_read or mN_write high; both high on one port SHALL be treated as a write.
REQ-004 At most one request SHALL be granted per cycle; a grant SHALL drive the granted port's fields combinationally onto ram_* with ram_chipselect=1 and ram_write = the write flag.
REQ-005 Arbitration SHALL be round-robin on a registered last_grant bit: with both ports requesting, the port not in last_grant wins; a lone requester always wins; last_grant SHALL update only on a grant.
REQ-006 The granted port's waitrequest SHALL be 0 in the grant cycle; every other requesting port SHALL see waitrequest=1 and hold its request stable.
REQ-007 An accepted read SHALL produce exactly one readdatavalid pulse on the issuing port in the next cycle, with readdata = ram_readdata (1-cycle latency), via a registered rd_pending/rd_port pair.
REQ-008 Back-to-back reads SHALL sustain one read per cycle; the return cycle SHALL NOT block a new grant.
REQ-009 An address >= DEPTH SHALL be accepted (waitrequest=0) but not issued (ram_chipselect=0): a write is dropped; a read returns 0 with readdatavalid on the next cycle; oor_err SHALL set and stay set until reset.
REQ-010 While reset_req=1: no new grant, both waitrequests=1, ram_clken=0; a read accepted in the preceding cycle SHALL still return its readdatavalid, with readdata = ram_readdata as presented in that return cycle (not guaranteed valid because ram_clken is low).
REQ-011 Otherwise ram_clken SHALL be 1; ram_* SHALL be 0 when there is no grant.
REQ-012 Address compare and data paths SHALL be pure width-matched; no arithmetic on data.

Reset
REQ-013 Asynchronous assert of reset SHALL immediately force: last_grant=1 (port 0 wins first contention), rd_pending=0, oor_err=0.
REQ-014 While reset=1, the following SHALL hold: both waitrequests=1, both readdatavalid=0, both readdata=0, ram_chipselect=0, ram_write=0, ram_clken=0, ram_address/byteenable/writedata=0.
REQ-015 A read in flight at reset assertion SHALL be discarded without a readdatavalid pulse.

Structure
REQ-016 ADDR_W, DATA_W and DEPTH defaults SHALL come from a shared package raytracing_ram_pkg, which also holds the port-ID type; the memory-side constants SHALL be shared with the RAM instance.
REQ-017 Arbitration SHALL be a sub-module raytracing_rr_arb2 (req[1:0] -> grant[1:0], last_grant register); the read-return tracking SHALL stay in the top module.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- m0 read 0x0010 alone, ram_readdata=0xDEADBEEF next cycle -> m0_waitrequest=0 in the request cycle; m0_readdatavalid=1 with m0_readdata=0xDEADBEEF one cycle later.
- Both ports write every cycle for 4 cycles after reset -> grants alternate m0,m1,m0,m1; each loser sees waitrequest=1.
- m1 write 0x12345678 to 0x9600 (38400) -> ram_chipselect=0, write dropped, oor_err=1 sticky; an m0 read of 0x95FF proceeds normally.
- m1 issues back-to-back reads of 0x0001,0x0002 -> two consecutive m1_readdatavalid pulses, in order, no bubble.
- reset_req=1 for 3 cycles while both request -> waitrequest=1 on both ports, ram_clken=0 throughout; arbitration resumes the cycle after deassertion.
- reset asserted one cycle after an accepted read -> no readdatavalid pulse; all outputs at reset values within the same cycle.
